// File: rtl/data_bus_responder.sv
// data_bus_responder
//   Slave end of the CPU data bus. Serves reads and byte-masked writes from a
//   word-organised on-chip RAM. Every access is stalled for WAIT_CYCLES
//   cycles and then completes in a single response cycle (RESP). Each
//   committed store is reported once through the wr_* commit record.
//
// Ports
//   clk       clock bundle: clk._50M rising-edge clock, clk.rst sync reset (active high)
//   address   byte address of the access; bits [1:0] are ignored
//   read      read request
//   write     write request
//   mask      byte enables for writes (bit i enables data_wr[8i+7:8i])
//   data_wr   write data
//   data_rd   read data; valid in RESP, held until the next read
//   stall     high while a request is pending and not in its response cycle
//   wr_valid  one-cycle pulse in RESP when a write commits
//   wr_addr   word-aligned byte address of the committed write
//   wr_data   full RAM word after the byte merge
//   err       one-cycle pulse in RESP for an out-of-range or read+write access

package data_bus_pkg;
  typedef struct packed {
    logic _50M;
    logic rst;
  } Clock_t;
endpackage

module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  Clock_t      clk,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  mask,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // The counter only ever holds WAIT_CYCLES-1 down to 1.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("data_bus_responder: WAIT_CYCLES must be at least 1");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("data_bus_responder: ADDR_WIDTH must be in 1..30");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // Request captured at acceptance; later changes on the bus are ignored.
  logic [29:0]     addr_reg;
  logic            read_reg;
  logic            write_reg;
  logic [3:0]      mask_reg;
  logic [31:0]     data_reg;

  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            from_idle;
  logic            enter_resp;
  logic [29:0]     acc_addr;
  logic            acc_read;
  logic            acc_write;
  logic [3:0]      acc_mask;
  logic [31:0]     acc_data;
  logic [31:0]     offset;
  logic            hit;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]     old_word;
  logic [31:0]     merged_word;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  assign req   = read | write;
  assign stall = req & (state_reg != RESP);

  // With WAIT_CYCLES == 1 the RESP entry edge is the acceptance edge itself,
  // so the live bus values must be used there instead of the latched copy.
  assign from_idle = (state_reg == IDLE);
  assign acc_addr  = from_idle ? address[31:2] : addr_reg;
  assign acc_read  = from_idle ? read          : read_reg;
  assign acc_write = from_idle ? write         : write_reg;
  assign acc_mask  = from_idle ? mask          : mask_reg;
  assign acc_data  = from_idle ? data_wr       : data_reg;

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far above the
  // RAM and are rejected as misses.
  assign offset   = {acc_addr, 2'b00} - BASE_ADDR;
  assign hit      = (offset >> (ADDR_WIDTH + 2)) == 32'd0;
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign old_word = mem[idx];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
    assign merged_word[8*gi +: 8] = acc_mask[gi] ? acc_data[8*gi +: 8]
                                                 : old_word[8*gi +: 8];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // Master withdrew: drop the access without touching RAM or outputs.
          state_next = IDLE;
        end else if (cnt_reg == CW'(1)) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk._50M) begin
    if (clk.rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      mask_reg  <= '0;
      data_reg  <= '0;
      data_rd   <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (from_idle && req) begin
        addr_reg  <= address[31:2];
        read_reg  <= read;
        write_reg <= write;
        mask_reg  <= mask;
        data_reg  <= data_wr;
      end
      wr_valid <= 1'b0;
      err      <= 1'b0;
      if (enter_resp) begin
        if (acc_write) begin
          // read+write together is served as a write but still flagged.
          if (hit) begin
            wr_valid <= 1'b1;
            wr_addr  <= {acc_addr, 2'b00};
            wr_data  <= merged_word;
          end
          err <= acc_read | ~hit;
        end else begin
          data_rd <= hit ? old_word : 32'h0000_0000;
          err     <= ~hit;
        end
      end
    end
  end

  // RAM has no reset so that a hierarchical preload survives srst.
  always_ff @(posedge clk._50M) begin
    if (!clk.rst && enter_resp && acc_write && hit) begin
      mem[idx] <= merged_word;
    end
  end

endmodule
